// File: rtl/spi_peripheral_pkg.sv
// Shared definitions for the SPI mode-0 responder and the register file
// that sits behind it: state encoding, byte width and opcode values.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMMAND = 2'd1,
        DATA    = 2'd2
    } spi_state_t;

    // Opcodes understood by the register file
    localparam logic [SPI_BYTE_W-1:0] OP_STATUS = 8'h07;
    localparam logic [SPI_BYTE_W-1:0] OP_READ   = 8'h10;
    localparam logic [SPI_BYTE_W-1:0] OP_WRITE  = 8'h20;

endpackage

// File: rtl/spi_peripheral_if.sv
// SPI pin bundle between the external controller and the responder.
interface spi_peripheral_if;

    logic sck;
    logic cs;
    logic copi;
    logic cipo;

    // Controller side drives clock, select and data out
    modport master (
        output sck,
        output cs,
        output copi,
        input  cipo
    );

    // Responder side
    modport slave (
        input  sck,
        input  cs,
        input  copi,
        output cipo
    );

endinterface

// File: rtl/spi_peripheral_input_sync.sv
// Multi-stage synchroniser for one asynchronous pin, with registered
// single-cycle rise and fall pulses taken from the synchronised level.
module spi_input_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;

    // Shift the pin through the chain and compare the last stage with its previous value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q  <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], d_i};
            prev_q  <= chain_q[SYNC_STAGES-1];
            rise_q  <= chain_q[SYNC_STAGES-1] & ~prev_q;
            fall_q  <= ~chain_q[SYNC_STAGES-1] & prev_q;
        end
    end

    assign level_o = chain_q[SYNC_STAGES-1];
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 responder. The first byte of each transaction is taken as the
// opcode; every later byte is presented on a write strobe while read bytes
// requested from the register file are shifted out on cipo, MSB first.
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    spi_peripheral_if.slave        spi,
    output logic [SPI_BYTE_W-1:0]  opcode,
    output logic                   opcode_valid,
    output logic [SPI_BYTE_W-1:0]  wr_byte,
    output logic                   wr_byte_valid,
    input  logic [SPI_BYTE_W-1:0]  rd_byte,
    output logic                   rd_byte_ack,
    output logic [COUNT_WIDTH-1:0] byte_count,
    output logic                   busy
);

    logic sckLevel, sckRise, sckFall;
    logic csLevel, csRise, csFall;
    logic copiLevel, copiRise, copiFall;
    logic unusedSync;

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sckSync (
        .clk(clk), .reset_n(reset_n), .d_i(spi.sck),
        .level_o(sckLevel), .rise_o(sckRise), .fall_o(sckFall)
    );

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_csSync (
        .clk(clk), .reset_n(reset_n), .d_i(spi.cs),
        .level_o(csLevel), .rise_o(csRise), .fall_o(csFall)
    );

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_copiSync (
        .clk(clk), .reset_n(reset_n), .d_i(spi.copi),
        .level_o(copiLevel), .rise_o(copiRise), .fall_o(copiFall)
    );

    assign unusedSync = sckLevel ^ csLevel ^ copiRise ^ copiFall;

    spi_state_t             state_q, state_d;
    logic [2:0]             bitCnt_q, bitCnt_d;
    logic [SPI_BYTE_W-1:0]  rxShift_q, rxShift_d;
    logic [SPI_BYTE_W-1:0]  txShift_q, txShift_d;
    logic                   cipo_q, cipo_d;
    logic [SPI_BYTE_W-1:0]  opcode_q, opcode_d;
    logic                   opcodeValid_q, opcodeValid_d;
    logic [SPI_BYTE_W-1:0]  wrByte_q, wrByte_d;
    logic                   wrByteValid_q, wrByteValid_d;
    logic                   rdByteAck_q, rdByteAck_d;
    logic [COUNT_WIDTH-1:0] byteCount_q, byteCount_d;
    logic [SPI_BYTE_W-1:0]  rxNext;
    logic [SPI_BYTE_W-1:0]  txNext;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            bitCnt_q      <= 3'd0;
            rxShift_q     <= '0;
            txShift_q     <= '0;
            cipo_q        <= 1'b0;
            opcode_q      <= '0;
            opcodeValid_q <= 1'b0;
            wrByte_q      <= '0;
            wrByteValid_q <= 1'b0;
            rdByteAck_q   <= 1'b0;
            byteCount_q   <= '0;
        end else begin
            state_q       <= state_d;
            bitCnt_q      <= bitCnt_d;
            rxShift_q     <= rxShift_d;
            txShift_q     <= txShift_d;
            cipo_q        <= cipo_d;
            opcode_q      <= opcode_d;
            opcodeValid_q <= opcodeValid_d;
            wrByte_q      <= wrByte_d;
            wrByteValid_q <= wrByteValid_d;
            rdByteAck_q   <= rdByteAck_d;
            byteCount_q   <= byteCount_d;
        end
    end

    // Next state: a cs release overrides any sck edge seen in the same cycle
    always_comb begin
        state_d       = state_q;
        bitCnt_d      = bitCnt_q;
        rxShift_d     = rxShift_q;
        txShift_d     = txShift_q;
        cipo_d        = cipo_q;
        opcode_d      = opcode_q;
        opcodeValid_d = 1'b0;
        wrByte_d      = wrByte_q;
        wrByteValid_d = 1'b0;
        rdByteAck_d   = 1'b0;
        byteCount_d   = byteCount_q;
        rxNext        = {rxShift_q[SPI_BYTE_W-2:0], copiLevel};
        txNext        = {txShift_q[SPI_BYTE_W-2:0], 1'b0};

        if (csRise) begin
            state_d   = IDLE;
            bitCnt_d  = 3'd0;
            txShift_d = '0;
            cipo_d    = 1'b0;
        end else if (state_q == IDLE) begin
            if (csFall) begin
                state_d     = COMMAND;
                bitCnt_d    = 3'd0;
                byteCount_d = '0;
                rxShift_d   = '0;
                txShift_d   = '0;
                cipo_d      = 1'b0;
            end
        end else if (sckRise) begin
            rxShift_d = rxNext;
            bitCnt_d  = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
                if (state_q == COMMAND) begin
                    opcode_d      = rxNext;
                    opcodeValid_d = 1'b1;
                    state_d       = DATA;
                end else begin
                    wrByte_d      = rxNext;
                    wrByteValid_d = 1'b1;
                    byteCount_d   = byteCount_q + COUNT_WIDTH'(1);
                end
            end
        end else if (sckFall) begin
            if (bitCnt_q == 3'd0 && state_q == DATA) begin
                txShift_d   = rd_byte;
                cipo_d      = rd_byte[SPI_BYTE_W-1];
                rdByteAck_d = 1'b1;
            end else begin
                txShift_d = txNext;
                cipo_d    = txNext[SPI_BYTE_W-1];
            end
        end
    end

    assign spi.cipo      = cipo_q;
    assign opcode        = opcode_q;
    assign opcode_valid  = opcodeValid_q;
    assign wr_byte       = wrByte_q;
    assign wr_byte_valid = wrByteValid_q;
    assign rd_byte_ack   = rdByteAck_q;
    assign byte_count    = byteCount_q;
    assign busy          = (state_q != IDLE);

endmodule
